// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq -- iterative AES SubBytes stage.
//
// Takes one 128-bit AES state over a valid/ready handshake, substitutes
// LANES bytes per cycle through sbox_element instances, then presents the
// result on a valid/ready output. It holds one state at a time.
//
// Byte k of a state is data[127-8k -: 8], column-major (k = row + 4*col).
//
// Parameters:
//   LANES      bytes substituted per cycle (1, 2, 4, 8 or 16)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream offers a state on in_data
//   in_ready   block can accept a state (IDLE only)
//   in_data    input state
//   out_valid  out_data holds a completed state
//   out_ready  downstream accepts out_data
//   out_data   substituted state, same byte order
//   busy       high while working or holding a result
//
// Build option:
//   SUBBYTES_SHIFTROWS_EN  when defined, ShiftRows is applied to the result
//                          as it is written to out_data (latency unchanged).

module sbox_element (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   logic [7:0] inv;

   always_comb begin
      inv      = gf_inv(in_byte);
      out_byte = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
   end

endmodule

module sub_bytes_seq #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int unsigned N  = 16 / LANES;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_next;
   logic [15:0][7:0] work, work_next;   // work[15-k] is byte k
   logic [CW-1:0]    cnt;
   logic             last;
   logic [7:0]       lane_in  [LANES];
   logic [7:0]       lane_out [LANES];

   function automatic logic [127:0] finish_bytes(input logic [15:0][7:0] s);
`ifdef SUBBYTES_SHIFTROWS_EN
      logic [15:0][7:0] o;
      o = '0;
      // out (r,c) takes sub byte (r,(c+r) mod 4)
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            o[4'(15 - (r + 4 * c))] = s[4'(15 - (r + 4 * ((c + r) % 4)))];
         end
      end
      return o;
`else
      return s;
`endif
   endfunction

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      sbox_element u_sbox (
         .in_byte  (lane_in[j]),
         .out_byte (lane_out[j])
      );
   end

   assign last = (cnt == CW'(N - 1));

   always_comb begin
      for (int unsigned j = 0; j < LANES; j++) begin
         lane_in[j] = work[4'(15 - (int'(cnt) * LANES + j))];
      end
   end

   always_comb begin
      work_next = work;
      for (int unsigned j = 0; j < LANES; j++) begin
         work_next[4'(15 - (int'(cnt) * LANES + j))] = lane_out[j];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         work     <= '0;
         cnt      <= '0;
         out_data <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work <= in_data;
                  cnt  <= '0;
               end
            end
            BUSY: begin
               work <= work_next;
               if (last) begin
                  cnt      <= '0;
                  out_data <= finish_bytes(work_next);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
